wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/riscv_pkg.sv | 13 +
 rtl/wb_match.sv | 31 +++
 rtl/wb_queue.sv | 123 ++++++++++++
 tb/tb_wb_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file constants and the pending-write entry type used by the
// write-back queue and its bench.
package riscv_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } pending_entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-first priority match over the held write-back entries; slot 0 is the
// oldest, so a later matching slot overrides an earlier one.
module wb_match
   import riscv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]                 slot_valid,
   input  logic [DEPTH-1:0][REG_ADDR_W-1:0] slot_rd,
   input  logic [DEPTH-1:0][WIDTH-1:0]      slot_data,
   input  logic [REG_ADDR_W-1:0]            q,
   output logic                             hit,
   output logic [WIDTH-1:0]                 data
);

   always_comb begin
      hit  = 1'b0;
      data = '0;
      // Register x0 is never forwarded.
      if (q != '0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (slot_rd[i] == q)) begin
               hit  = 1'b1;
               data = slot_data[i];
            end
         end
      end
   end

endmodule

// File: rtl/wb_queue.sv
// Pending register-file write queue: drains one entry per cycle into the
// register file and optionally forwards held data (build with WB_BYPASS_EN).
module wb_queue
   import riscv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [REG_ADDR_W-1:0]     in_rd,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      we3,
   output logic [REG_ADDR_W-1:0]     a3,
   output logic [WIDTH-1:0]          wd3,
   input  logic [REG_ADDR_W-1:0]     q1,
   input  logic [REG_ADDR_W-1:0]     q2,
   output logic                      fwd1_hit,
   output logic                      fwd2_hit,
   output logic [WIDTH-1:0]          fwd1_data,
   output logic [WIDTH-1:0]          fwd2_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [REG_ADDR_W-1:0] rd_mem_q   [DEPTH];
   logic [REG_ADDR_W-1:0] rd_mem_d   [DEPTH];
   logic [WIDTH-1:0]      data_mem_q [DEPTH];
   logic [WIDTH-1:0]      data_mem_d [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  push, pop;

   always_comb begin
      in_ready   = (count_q != CW'(DEPTH));
      empty      = (count_q == '0);
      pop        = !empty;
      // Writes to x0 are accepted but never stored.
      push       = in_valid && in_ready && (in_rd != '0);
      rd_mem_d   = rd_mem_q;
      data_mem_d = data_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push) begin
         rd_mem_d[wr_ptr_q]   = in_rd;
         data_mem_d[wr_ptr_q] = in_data;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      count   = count_q;
      we3     = pop;
      a3      = pop ? rd_mem_q[rd_ptr_q]   : '0;
      wd3     = pop ? data_mem_q[rd_ptr_q] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is qualified by the pointers and count, so it carries no reset.
   always_ff @(posedge clk) begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
   end

`ifdef WB_BYPASS_EN
   logic [DEPTH-1:0]                 ord_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] ord_rd;
   logic [DEPTH-1:0][WIDTH-1:0]      ord_data;

   // Rotate storage into age order (slot 0 = head) for the priority match.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ord_valid[i] = (CW'(i) < count_q);
         ord_rd[i]    = rd_mem_q[rd_ptr_q + PW'(i)];
         ord_data[i]  = data_mem_q[rd_ptr_q + PW'(i)];
      end
   end

   wb_match #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_match1 (
      .slot_valid (ord_valid),
      .slot_rd    (ord_rd),
      .slot_data  (ord_data),
      .q          (q1),
      .hit        (fwd1_hit),
      .data       (fwd1_data)
   );

   wb_match #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_match2 (
      .slot_valid (ord_valid),
      .slot_rd    (ord_rd),
      .slot_data  (ord_data),
      .q          (q2),
      .hit        (fwd2_hit),
      .data       (fwd2_data)
   );
`else
   logic unused_q;
   assign unused_q  = ^{q1, q2};
   assign fwd1_hit  = 1'b0;
   assign fwd2_hit  = 1'b0;
   assign fwd1_data = '0;
   assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed table, hand sequences for reset and back-to-back
// pushes, and random traffic against a queue-based reference model.
module tb_wb_queue;
   import riscv_pkg::*;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [REG_ADDR_W-1:0] in_rd = '0;
   logic [WIDTH-1:0]      in_data = '0;
   logic                  we3;
   logic [REG_ADDR_W-1:0] a3;
   logic [WIDTH-1:0]      wd3;
   logic [REG_ADDR_W-1:0] q1 = '0;
   logic [REG_ADDR_W-1:0] q2 = '0;
   logic                  fwd1_hit, fwd2_hit;
   logic [WIDTH-1:0]      fwd1_data, fwd2_data;
   logic [CW-1:0]         count;
   logic                  empty;

   int n_vec = 0;
   int n_err = 0;

   pending_entry_t exp_q[$];

   wb_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rd     (in_rd),
      .in_data   (in_data),
      .we3       (we3),
      .a3        (a3),
      .wd3       (wd3),
      .q1        (q1),
      .q2        (q2),
      .fwd1_hit  (fwd1_hit),
      .fwd2_hit  (fwd2_hit),
      .fwd1_data (fwd1_data),
      .fwd2_data (fwd2_data),
      .count     (count),
      .empty     (empty)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Youngest matching held entry wins; x0 never forwards.
   task automatic lookup(input logic [REG_ADDR_W-1:0] q, output logic hit, output logic [WIDTH-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (BYP && q != '0) begin
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].rd == q) begin
               hit = 1'b1;
               d   = exp_q[i].data;
               break;
            end
         end
      end
   endtask

   task automatic compare_model();
      logic h;
      logic [WIDTH-1:0] d;
      int sz;
      sz = exp_q.size();
      check("count", count, sz);
      check("empty", empty, sz == 0);
      check("in_ready", in_ready, sz != DEPTH);
      check("we3", we3, sz != 0);
      check("a3", a3, (sz != 0) ? exp_q[0].rd : '0);
      check("wd3", wd3, (sz != 0) ? exp_q[0].data : '0);
      lookup(q1, h, d);
      check("fwd1_hit", fwd1_hit, h);
      check("fwd1_data", fwd1_data, d);
      lookup(q2, h, d);
      check("fwd2_hit", fwd2_hit, h);
      check("fwd2_data", fwd2_data, d);
   endtask

   // driver: inputs change on the falling edge
   task automatic drive(input logic r, input logic v, input logic [4:0] rd, input logic [31:0] dat,
                        input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      rst_n    = r;
      in_valid = v;
      in_rd    = rd;
      in_data  = dat;
      q1       = a1;
      q2       = a2;
      #1;
   endtask

   // Reference behaviour at the rising edge: pop head if any, then append
   // an accepted non-x0 write.
   task automatic model_edge();
      bit ready;
      pending_entry_t e;
      @(posedge clk);
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         ready = (exp_q.size() != DEPTH);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         if (in_valid && ready && in_rd != '0) begin
            e.rd   = in_rd;
            e.data = in_data;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [4:0] rd, input logic [31:0] dat,
                       input logic [4:0] a1, input logic [4:0] a2, input bit chk);
      drive(r, v, rd, dat, a1, a2);
      if (chk) compare_model();
      model_edge();
   endtask

   typedef struct {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [4:0]  q1;
      logic        e_we3;
      logic [4:0]  e_a3;
      logic [31:0] e_wd3;
      logic [2:0]  e_count;
      logic        e_f1hit;
      logic [31:0] e_f1data;
   } row_t;

   function automatic row_t mk(logic v, logic [4:0] rd, logic [31:0] dat, logic [4:0] a1,
                               logic we, logic [4:0] ea3, logic [31:0] ewd, logic [2:0] ec,
                               logic fh, logic [31:0] fd);
      row_t r;
      r.valid = v; r.rd = rd; r.data = dat; r.q1 = a1;
      r.e_we3 = we; r.e_a3 = ea3; r.e_wd3 = ewd; r.e_count = ec;
      r.e_f1hit = fh; r.e_f1data = fd;
      return r;
   endfunction

   row_t tbl[9];

   initial begin
      tbl[0] = mk(1, 5'd5, 32'h11, 0, 0, 0, 0,     0, 0, 0);
      tbl[1] = mk(0, 0,    0,      0, 1, 5, 32'h11, 1, 0, 0);
      tbl[2] = mk(0, 0,    0,      0, 0, 0, 0,     0, 0, 0);
      tbl[3] = mk(1, 5'd0, 32'hFF, 0, 0, 0, 0,     0, 0, 0);
      tbl[4] = mk(0, 0,    0,      0, 0, 0, 0,     0, 0, 0);
      tbl[5] = mk(1, 5'd7, 32'hA,  7, 0, 0, 0,     0, 0, 0);
      tbl[6] = mk(1, 5'd7, 32'hB,  7, 1, 7, 32'hA, 1, BYP, BYP ? 32'hA : 32'h0);
      tbl[7] = mk(0, 0,    0,      7, 1, 7, 32'hB, 1, BYP, BYP ? 32'hB : 32'h0);
      tbl[8] = mk(0, 0,    0,      7, 0, 0, 0,     0, 0, 0);

      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // directed table (first row also observes the post-reset state)
      for (int i = 0; i < 9; i++) begin
         drive(1, tbl[i].valid, tbl[i].rd, tbl[i].data, tbl[i].q1, 5'd0);
         compare_model();
         check("tbl_we3", we3, tbl[i].e_we3);
         check("tbl_a3", a3, tbl[i].e_a3);
         check("tbl_wd3", wd3, tbl[i].e_wd3);
         check("tbl_count", count, tbl[i].e_count);
         check("tbl_f1hit", fwd1_hit, tbl[i].e_f1hit);
         check("tbl_f1data", fwd1_data, tbl[i].e_f1data);
         check("tbl_f2hit", fwd2_hit, 1'b0);
         model_edge();
      end

      // reset while an entry is draining
      step(1, 1, 5'd9,  32'h55, 9, 10, 1);
      step(1, 1, 5'd10, 32'h66, 9, 10, 1);
      step(0, 1, 5'd11, 32'h77, 9, 10, 1);
      drive(1, 0, 0, 0, 10, 11);
      compare_model();
      check("rst_count", count, 0);
      check("rst_we3", we3, 1'b0);
      check("rst_ready", in_ready, 1'b1);
      check("rst_f1hit", fwd1_hit, 1'b0);
      model_edge();

      // back-to-back pushes across a pointer wrap; each write leaves next cycle
      for (int i = 0; i < 2 * DEPTH; i++) begin
         drive(1, 1, 5'(i + 1), 32'(32'h100 + i), 5'(i), 5'(i + 1));
         compare_model();
         if (i > 0) begin
            check("b2b_a3", a3, 5'(i));
            check("b2b_wd3", wd3, 32'(32'h100 + i - 1));
         end
         model_edge();
      end
      step(1, 0, 0, 0, 0, 0, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
              $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
